// File: rtl/stats_poller_avlstrm_pkg.sv
// Shared definitions for the status register bus: register map, address
// layout and the poller FSM encoding.
package stats_poller_avlstrm_pkg;

    localparam int unsigned STAT_AWIDTH = 4;
    localparam int unsigned NUM_REG     = 64;
    localparam int unsigned AVL_DW      = 64;

    localparam logic [STAT_AWIDTH-1:0] TOP_REG      = 4'hA;
    localparam logic [7:0]             REG_CTRL     = 8'hF0;
    localparam logic [7:0]             REG_NOTUSED  = 8'hFF;
    localparam logic [31:0]            TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef logic [31:0] stats_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_DONE
    } poll_state_e;

    // Bus address: select field on top, register index in the low byte.
    function automatic logic [29:0] stat_addr(input logic [STAT_AWIDTH-1:0] sel,
                                              input logic [7:0]             regno);
        return {sel, {(30-STAT_AWIDTH-8){1'b0}}, regno};
    endfunction

endpackage

// File: rtl/avl_stream_if.sv
// Single-beat Avalon-ST style channel used by the status register bus.
interface avl_stream_if;
    import stats_poller_avlstrm_pkg::*;

    logic              valid;
    logic              ready;
    logic              sop;
    logic              eop;
    logic [AVL_DW-1:0] data;

    modport tx (output valid, sop, eop, data, input ready);
    modport rx (input valid, sop, eop, data, output ready);
endinterface

// File: rtl/stats_snap_ram.sv
// Snapshot buffer: one write port, one registered read port. Contents are
// not reset; only the read register is.
module stats_snap_ram
    import stats_poller_avlstrm_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  stats_t        wdata,
    input  logic [AW-1:0] raddr,
    output stats_t        rdata
);

    stats_t mem_q [DEPTH];
    stats_t rdata_q;

    always_ff @(posedge Clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read-before-write: a same-cycle write is not visible to this read.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/stats_poller_avlstrm.sv
// Status bus requester: sweeps a register window into a snapshot buffer
// and issues single control writes.
module stats_poller_avlstrm
    import stats_poller_avlstrm_pkg::*;
#(
    parameter int unsigned             FIRST_REG = 0,
    parameter int unsigned             NUM_POLL  = 16,
    parameter logic [STAT_AWIDTH-1:0]  SEL       = TOP_REG,
    parameter int unsigned             TIMEOUT   = 64,
    localparam int unsigned            IDX_W     = (NUM_POLL > 1) ? $clog2(NUM_POLL) : 1
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                start,
    input  logic                ctrl_wr,
    input  logic [31:0]         ctrl_wdata,
    output logic                busy,
    output logic                sweep_done,
    output logic [NUM_POLL-1:0] err_map,
    output logic [15:0]         timeout_cnt,
    input  logic [IDX_W-1:0]    snap_raddr,
    output stats_t              snap_rdata,
    avl_stream_if.tx            stats_wreq,
    avl_stream_if.tx            stats_rreq,
    avl_stream_if.rx            stats_rresp
);

    localparam int unsigned        CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]   WCNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_POLL - 1);

    poll_state_e         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic [NUM_POLL-1:0] err_map_q, err_map_d;
    logic [15:0]         tocnt_q, tocnt_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                ram_we;
    stats_t              ram_wdata;
    logic                rd_finish;
    logic [7:0]          reg_sel;
    logic                unused_resp;

    assign reg_sel = 8'(FIRST_REG) + 8'(idx_q);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            wcnt_q    <= '0;
            err_map_q <= '0;
            tocnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wcnt_q    <= wcnt_d;
            err_map_q <= err_map_d;
            tocnt_q   <= tocnt_d;
        end
    end

    // Control write data is captured on entry to WR and held until accepted.
    always_ff @(posedge Clk) begin
        wdata_q <= wdata_d;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        err_map_d = err_map_q;
        tocnt_d   = tocnt_q;
        wdata_d   = wdata_q;
        ram_we    = 1'b0;
        ram_wdata = stats_rresp.data[31:0];
        rd_finish = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_wr) begin
                    state_d = ST_WR;
                    wdata_d = ctrl_wdata;
                end else if (start) begin
                    state_d = ST_RD_ISSUE;
                    idx_d   = '0;
                end
            end
            ST_WR: begin
                if (stats_wreq.ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                if (stats_rreq.ready) begin
                    state_d = ST_RD_WAIT;
                    wcnt_d  = '0;
                end
            end
            ST_RD_WAIT: begin
                wcnt_d = wcnt_q + CNT_W'(1);
                // A reply in the final wait cycle still counts as a reply.
                if (stats_rresp.valid) begin
                    ram_we           = 1'b1;
                    err_map_d[idx_q] = 1'b0;
                    rd_finish        = 1'b1;
                end else if (wcnt_q == WCNT_LAST) begin
                    ram_we           = 1'b1;
                    ram_wdata        = TIMEOUT_DATA;
                    err_map_d[idx_q] = 1'b1;
                    rd_finish        = 1'b1;
                    if (tocnt_q != 16'hFFFF) begin
                        tocnt_d = tocnt_q + 16'd1;
                    end
                end
                if (rd_finish) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign sweep_done  = (state_q == ST_DONE);
    assign err_map     = err_map_q;
    assign timeout_cnt = tocnt_q;

    assign stats_wreq.valid = (state_q == ST_WR);
    assign stats_wreq.sop   = 1'b1;
    assign stats_wreq.eop   = 1'b1;
    assign stats_wreq.data  = {2'b00, stat_addr(SEL, REG_CTRL), wdata_q};

    assign stats_rreq.valid = (state_q == ST_RD_ISSUE);
    assign stats_rreq.sop   = 1'b1;
    assign stats_rreq.eop   = 1'b1;
    assign stats_rreq.data  = {34'd0, stat_addr(SEL, reg_sel)};

    assign stats_rresp.ready = 1'b1;
    assign unused_resp = ^{stats_rresp.sop, stats_rresp.eop, stats_rresp.data[AVL_DW-1:32]};

    stats_snap_ram #(
        .DEPTH (NUM_POLL),
        .AW    (IDX_W)
    ) u_snap_ram (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .we    (ram_we),
        .waddr (idx_q),
        .wdata (ram_wdata),
        .raddr (snap_raddr),
        .rdata (snap_rdata)
    );

endmodule

// File: tb/tb_stats_poller_avlstrm.sv
// Directed bench for stats_poller_avlstrm with a 2-cycle responder model.
module tb_stats_poller_avlstrm;
    import stats_poller_avlstrm_pkg::*;

    localparam int NP = 16;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        start;
    logic        ctrl_wr;
    logic [31:0] ctrl_wdata;
    logic        busy;
    logic        sweep_done;
    logic [15:0] err_map;
    logic [15:0] timeout_cnt;
    logic [3:0]  snap_raddr;
    logic [31:0] snap_rdata;

    avl_stream_if wreq_if ();
    avl_stream_if rreq_if ();
    avl_stream_if rresp_if ();

    always #5 Clk = ~Clk;

    stats_poller_avlstrm dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .start       (start),
        .ctrl_wr     (ctrl_wr),
        .ctrl_wdata  (ctrl_wdata),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .err_map     (err_map),
        .timeout_cnt (timeout_cnt),
        .snap_raddr  (snap_raddr),
        .snap_rdata  (snap_rdata),
        .stats_wreq  (wreq_if),
        .stats_rreq  (rreq_if),
        .stats_rresp (rresp_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Responder / ready control, all sampled on the falling edge.
    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;
    rsp_t rq[$];

    int          cyc = 0;
    int          stall_reg = -1, stall_len = 5, stall_cnt = 0;
    int          mute_reg = -1, slow_reg = -1, slow_delay = 2;
    int          rd_accepts = 0, next_reg = 0;
    logic [63:0] stall_addr;
    int          wstall_len = 0, wstall_cnt = 0, wr_beats = 0;
    logic [63:0] wr_first, wr_data;
    logic [1:0]  wr_sopeop;

    always @(negedge Clk) begin
        int          hit;
        int          rn;
        cyc++;
        rn = int'(rreq_if.data[7:0]);
        if (stall_cnt > 0 && stall_cnt < stall_len) begin
            chk("stall_valid_held", 64'(rreq_if.valid), 64'd1);
            chk("stall_addr_held", rreq_if.data, stall_addr);
            stall_cnt++;
            rreq_if.ready = 1'b0;
        end else if (stall_cnt == 0 && rreq_if.valid === 1'b1 && rn == stall_reg) begin
            stall_addr    = rreq_if.data;
            stall_cnt     = 1;
            rreq_if.ready = 1'b0;
        end else begin
            rreq_if.ready = 1'b1;
        end
        if (rreq_if.valid === 1'b1 && rreq_if.ready === 1'b1) begin
            rd_accepts++;
            chk("rd_reg_seq", 64'(rn), 64'(next_reg));
            chk("rd_addr_hi", 64'(rreq_if.data[63:8]), 64'h28_0000);
            chk("rd_sop_eop", 64'({rreq_if.sop, rreq_if.eop}), 64'd3);
            next_reg++;
            if (rn != mute_reg) begin
                rq.push_back('{cyc + ((rn == slow_reg) ? slow_delay : 2), 32'h100 + 32'(rn)});
            end
        end
        rresp_if.valid = 1'b0;
        rresp_if.sop   = 1'b1;
        rresp_if.eop   = 1'b1;
        rresp_if.data  = '0;
        hit = -1;
        foreach (rq[k]) if (rq[k].due == cyc && hit < 0) hit = k;
        if (hit >= 0) begin
            rresp_if.valid = 1'b1;
            rresp_if.data  = {32'd0, rq[hit].data};
            rq.delete(hit);
        end

        if (wreq_if.valid === 1'b1 && wstall_cnt < wstall_len) begin
            if (wstall_cnt == 0) wr_first = wreq_if.data;
            else chk("wr_data_held", wreq_if.data, wr_first);
            wstall_cnt++;
            wreq_if.ready = 1'b0;
        end else begin
            wreq_if.ready = 1'b1;
        end
        if (wreq_if.valid === 1'b1 && wreq_if.ready === 1'b1) begin
            wr_beats++;
            wr_data   = wreq_if.data;
            wr_sopeop = {wreq_if.sop, wreq_if.eop};
        end
    end

    typedef struct {
        string       name;
        int          stall_reg;
        int          mute_reg;
        int          slow_reg;
        int          slow_delay;
        int          exp_cycles;
        logic [15:0] exp_err;
        logic [15:0] exp_tocnt;
        int          o0_idx;
        logic [31:0] o0_val;
        int          o1_idx;
        logic [31:0] o1_val;
    } vec_t;

    vec_t vecs[5];

    task automatic run_sweep(input vec_t v);
        int          n;
        bit          seen;
        logic [31:0] exp;
        stall_reg  = v.stall_reg;
        stall_cnt  = 0;
        mute_reg   = v.mute_reg;
        slow_reg   = v.slow_reg;
        slow_delay = v.slow_delay;
        rd_accepts = 0;
        next_reg   = 0;
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk({v.name, "_busy"}, 64'(busy), 64'd1);
        n    = 1;
        seen = 1'b0;
        while (!seen && n < 1000) begin
            if (sweep_done) seen = 1'b1;
            else begin
                @(negedge Clk);
                n++;
            end
        end
        chk({v.name, "_cycles"}, seen ? 64'(n) : 64'hFFFF, 64'(v.exp_cycles));
        @(negedge Clk);
        chk({v.name, "_done_pulse"}, 64'(sweep_done), 64'd0);
        chk({v.name, "_idle"}, 64'(busy), 64'd0);
        chk({v.name, "_accepts"}, 64'(rd_accepts), 64'(NP));
        chk({v.name, "_err_map"}, 64'(err_map), 64'(v.exp_err));
        chk({v.name, "_timeout_cnt"}, 64'(timeout_cnt), 64'(v.exp_tocnt));
        for (int i = 0; i < NP; i++) begin
            exp = 32'h100 + 32'(i);
            if (i == v.o0_idx) exp = v.o0_val;
            if (i == v.o1_idx) exp = v.o1_val;
            snap_raddr = 4'(i);
            @(negedge Clk);
            chk($sformatf("%s_snap%0d", v.name, i), 64'(snap_rdata), 64'(exp));
        end
    endtask

    initial begin
        int n;
        bit seen;
        vecs[0] = '{"plain",  -1, -1, -1,  2,  49, 16'h0000, 16'd0, -1, 32'h0,        -1, 32'h0};
        vecs[1] = '{"stall3",  3, -1, -1,  2,  54, 16'h0000, 16'd0, -1, 32'h0,        -1, 32'h0};
        vecs[2] = '{"mute7",  -1,  7, -1,  2, 111, 16'h0080, 16'd1,  7, 32'hDEADBEEF, -1, 32'h0};
        vecs[3] = '{"edge7",  -1, -1,  7, 64, 111, 16'h0000, 16'd1, -1, 32'h0,        -1, 32'h0};
        vecs[4] = '{"late7",  -1, -1,  7, 66, 110, 16'h0080, 16'd2,  7, 32'hDEADBEEF,  8, 32'h107};

        Rst_n      = 1'b0;
        start      = 1'b0;
        ctrl_wr    = 1'b0;
        ctrl_wdata = '0;
        snap_raddr = '0;
        repeat (3) @(negedge Clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sweep_done", 64'(sweep_done), 64'd0);
        chk("rst_rreq_valid", 64'(rreq_if.valid), 64'd0);
        chk("rst_wreq_valid", 64'(wreq_if.valid), 64'd0);
        chk("rst_err_map", 64'(err_map), 64'd0);
        chk("rst_timeout_cnt", 64'(timeout_cnt), 64'd0);
        chk("rst_snap_rdata", 64'(snap_rdata), 64'd0);
        chk("rresp_ready", 64'(rresp_if.ready), 64'd1);
        Rst_n = 1'b1;
        @(negedge Clk);

        for (int v = 0; v < 5; v++) begin
            run_sweep(vecs[v]);
        end

        // Control write and start in the same cycle: write wins, start is lost.
        stall_reg  = -1;
        mute_reg   = -1;
        slow_reg   = -1;
        wstall_len = 2;
        wstall_cnt = 0;
        wr_beats   = 0;
        rd_accepts = 0;
        @(negedge Clk);
        ctrl_wr    = 1'b1;
        start      = 1'b1;
        ctrl_wdata = 32'h5;
        @(negedge Clk);
        ctrl_wr    = 1'b0;
        start      = 1'b0;
        ctrl_wdata = 32'hFFFF_FFFF;
        chk("wr_busy", 64'(busy), 64'd1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge Clk);
            if (sweep_done) seen = 1'b1;
        end
        chk("wr_beats", 64'(wr_beats), 64'd1);
        chk("wr_addr", 64'(wr_data[61:32]), 64'h2800_00F0);
        chk("wr_payload", 64'(wr_data[31:0]), 64'h5);
        chk("wr_top_bits", 64'(wr_data[63:62]), 64'd0);
        chk("wr_sop_eop", 64'(wr_sopeop), 64'd3);
        chk("wr_no_read", 64'(rd_accepts), 64'd0);
        chk("wr_no_sweep_done", 64'(seen), 64'd0);
        chk("wr_idle", 64'(busy), 64'd0);
        wstall_len = 0;

        // Reset while waiting on idx 5's reply.
        rd_accepts = 0;
        next_reg   = 0;
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        n = 0;
        while (rd_accepts < 6 && n < 200) begin
            @(negedge Clk);
            #1;
            n++;
        end
        chk("rst_reach_idx5", 64'(rd_accepts), 64'd6);
        @(negedge Clk);
        chk("rst_pre_busy", 64'(busy), 64'd1);
        Rst_n = 1'b0;
        @(negedge Clk);
        chk("rst_mid_rreq_valid", 64'(rreq_if.valid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_sweep_done", 64'(sweep_done), 64'd0);
        chk("rst_mid_err_map", 64'(err_map), 64'd0);
        chk("rst_mid_timeout_cnt", 64'(timeout_cnt), 64'd0);
        chk("rst_mid_snap_rdata", 64'(snap_rdata), 64'd0);
        Rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge Clk);
            if (sweep_done) seen = 1'b1;
        end
        chk("rst_no_sweep_done", 64'(seen), 64'd0);
        chk("rst_no_more_reads", 64'(rd_accepts), 64'd6);
        run_sweep(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
